// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - opcodes, state encodings, IR fields and class flags for the control sequencer
package control_sequencer_pkg;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  localparam int C_HI  = 18;
  localparam int C_LO  = 0;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  typedef struct packed {
    logic alu_r;
    logic alu_i;
    logic unary;
    logic mem;
    logic br;
    logic io;
    logic muldiv;
    logic halt;
  } opclass_t;

endpackage

// File: rtl/control_sequencer_ir_opclass_decode.sv
// rtl/control_sequencer_ir_opclass_decode.sv - opcode to class flags; mul/div only with CONTROL_SEQ_MULDIV_EN
module ir_opclass_decode
  import control_sequencer_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] op_i,
  output opclass_t       cls_o
);

  // An all-zero class means nop or undefined: no execute cycles.
  always_comb begin
    cls_o = '0;
    case (op_i) inside
      [OP_ADD:OP_ROL]:                       cls_o.alu_r = 1'b1;
      [OP_ADDI:OP_ORI]:                      cls_o.alu_i = 1'b1;
      OP_NEG, OP_NOT:                        cls_o.unary = 1'b1;
      OP_LD, OP_LDI, OP_ST:                  cls_o.mem   = 1'b1;
      OP_BR:                                 cls_o.br    = 1'b1;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: cls_o.io   = 1'b1;
`ifdef CONTROL_SEQ_MULDIV_EN
      OP_MUL, OP_DIV:                        cls_o.muldiv = 1'b1;
`endif
      OP_HALT:                               cls_o.halt  = 1'b1;
      default:                               cls_o = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hard-wired T0..T7 sequencer and strobe decode for Datapath_P2
// Optional mul/div execute steps enabled by CONTROL_SEQ_MULDIV_EN.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPW    = 5,
  parameter int STATEW = 4
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic [31:0]    IR,
  input  logic           CON_FF,
  input  logic           Stop,
  output logic [OPW-1:0] alu_op,
  output logic           Run,
  output logic           PCout,
  output logic           Zhiout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           InPortout,
  output logic           HIout,
  output logic           LOout,
  output logic           BAout,
  output logic           Cout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           OutPortin,
  output logic           HIin,
  output logic           LOin,
  output logic           Rin,
  output logic           Rout,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           IncPC,
  output logic           Read,
  output logic           Write,
  output logic           CONin,
  output logic           Strobe
);

  logic [STATEW-1:0] state_q, state_d;
  logic [OPW-1:0]    op;
  opclass_t          cls;
  logic              last_step;
  logic [STATEW-1:0] done_state;
  logic              unused_ir;

  assign op        = IR[OP_HI:OP_LO];
  assign unused_ir = ^IR[RA_HI:0];

  ir_opclass_decode #(.OPW(OPW)) u_decode (
    .op_i  (op),
    .cls_o (cls)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // Final execute step per class; T7 always terminates so a stray IR cannot wedge the FSM.
  always_comb begin
    last_step = 1'b0;
    case (state_q)
      S_T3:    last_step = cls.io;
      S_T4:    last_step = cls.unary;
      S_T5:    last_step = cls.alu_r | cls.alu_i | (cls.mem && op == OP_LDI);
      S_T6:    last_step = cls.br | cls.muldiv;
      S_T7:    last_step = 1'b1;
      default: last_step = 1'b0;
    endcase
  end

  assign done_state = Stop ? S_HALT : S_T0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2: begin
        if (cls.halt)     state_d = S_HALT;
        else if (cls == '0) state_d = done_state;
        else              state_d = S_T3;
      end
      S_T3:   state_d = last_step ? done_state : S_T4;
      S_T4:   state_d = last_step ? done_state : S_T5;
      S_T5:   state_d = last_step ? done_state : S_T6;
      S_T6:   state_d = last_step ? done_state : S_T7;
      S_T7:   state_d = done_state;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    alu_op = '0;
    Run = (state_q != S_RST) && (state_q != S_HALT);
    {PCout, Zhiout, Zlowout, MDRout, InPortout, HIout, LOout, BAout, Cout} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, HIin, LOin, Rin, Rout} = '0;
    {Gra, Grb, Grc, IncPC, Read, Write, CONin, Strobe} = '0;
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (cls.alu_r || cls.alu_i) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        if (cls.unary) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
        if (cls.mem)   begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        if (cls.br)    begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
        if (op == OP_JR)   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
        if (op == OP_IN)   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        if (op == OP_OUT)  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; Strobe = 1'b1; end
        if (op == OP_MFHI) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        if (op == OP_MFLO) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
`ifdef CONTROL_SEQ_MULDIV_EN
        if (cls.muldiv) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
`endif
      end
      S_T4: begin
        if (cls.alu_r) begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
        if (cls.alu_i) begin Cout = 1'b1; Zin = 1'b1; alu_op = op; end
        if (cls.unary) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        if (cls.mem)   begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
        if (cls.br)    begin PCout = 1'b1; Yin = 1'b1; end
`ifdef CONTROL_SEQ_MULDIV_EN
        if (cls.muldiv) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op; end
`endif
      end
      S_T5: begin
        if (cls.alu_r || cls.alu_i || (cls.mem && op == OP_LDI)) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
        if (op == OP_LD || op == OP_ST) begin Zlowout = 1'b1; MARin = 1'b1; end
        if (cls.br) begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
`ifdef CONTROL_SEQ_MULDIV_EN
        if (cls.muldiv) begin Zlowout = 1'b1; LOin = 1'b1; end
`endif
      end
      S_T6: begin
        if (op == OP_LD) begin Read = 1'b1; MDRin = 1'b1; end
        if (op == OP_ST) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        if (cls.br && CON_FF) begin Zlowout = 1'b1; PCin = 1'b1; end
`ifdef CONTROL_SEQ_MULDIV_EN
        if (cls.muldiv) begin Zhiout = 1'b1; HIin = 1'b1; end
`endif
      end
      S_T7: begin
        if (op == OP_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        if (op == OP_ST) Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear, CON_FF, Stop;
  logic [31:0] IR;
  logic [4:0]  alu_op;
  logic        Run;
  logic PCout, Zhiout, Zlowout, MDRout, InPortout, HIout, LOout, BAout, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, HIin, LOin, Rin, Rout;
  logic Gra, Grb, Grc, IncPC, Read, Write, CONin, Strobe;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [27:0] PCOUT = 28'd1 << 27, ZHIOUT = 28'd1 << 26, ZLOWOUT = 28'd1 << 25;
  localparam logic [27:0] MDROUT = 28'd1 << 24, INPORTOUT = 28'd1 << 23, HIOUT = 28'd1 << 22;
  localparam logic [27:0] LOOUT = 28'd1 << 21, BAOUT = 28'd1 << 20, COUT = 28'd1 << 19;
  localparam logic [27:0] MARIN = 28'd1 << 18, ZIN = 28'd1 << 17, PCIN = 28'd1 << 16;
  localparam logic [27:0] MDRIN = 28'd1 << 15, IRIN = 28'd1 << 14, YIN = 28'd1 << 13;
  localparam logic [27:0] OUTPORTIN = 28'd1 << 12, HIIN = 28'd1 << 11, LOIN = 28'd1 << 10;
  localparam logic [27:0] RIN = 28'd1 << 9, ROUT = 28'd1 << 8, GRA = 28'd1 << 7, GRB = 28'd1 << 6;
  localparam logic [27:0] GRC = 28'd1 << 5, INCPC = 28'd1 << 4, READ = 28'd1 << 3;
  localparam logic [27:0] WRITE = 28'd1 << 2, CONIN = 28'd1 << 1, STROBE = 28'd1;

  logic [27:0] sv;
  assign sv = {PCout, Zhiout, Zlowout, MDRout, InPortout, HIout, LOout, BAout, Cout,
               MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, HIin, LOin, Rin, Rout,
               Gra, Grb, Grc, IncPC, Read, Write, CONin, Strobe};

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .alu_op(alu_op), .Run(Run),
    .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
    .InPortout(InPortout), .HIout(HIout), .LOout(LOout), .BAout(BAout), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .OutPortin(OutPortin), .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
    .CONin(CONin), .Strobe(Strobe)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [27:0] es, input logic [4:0] eo, input logic er);
    n_assert++;
    assert (sv === es) else begin
      n_fail++; $error("FAIL %s strobes got %07h exp %07h", tag, sv, es);
    end
    n_assert++;
    assert (alu_op === eo) else begin
      n_fail++; $error("FAIL %s alu_op got %b exp %b", tag, alu_op, eo);
    end
    n_assert++;
    assert (Run === er) else begin
      n_fail++; $error("FAIL %s Run got %b exp %b", tag, Run, er);
    end
    n_assert++;
    assert (($countones(sv[27:19]) <= 1) === 1'b1) else begin
      n_fail++; $error("FAIL %s bus_onehot got %09b exp at most one", tag, sv[27:19]);
    end
  endtask

  task automatic step();
    @(negedge Clock);
  endtask

  // T0..T2 checks; the next instruction is loaded into IR while in T0.
  task automatic fetch(input string tag, input logic [31:0] next_ir);
    step(); chk({tag, "_T0"}, PCOUT | MARIN | INCPC | ZIN, 5'b0, 1'b1);
    IR = next_ir;
    step(); chk({tag, "_T1"}, ZLOWOUT | PCIN | READ | MDRIN, 5'b0, 1'b1);
    step(); chk({tag, "_T2"}, MDROUT | IRIN, 5'b0, 1'b1);
  endtask

  initial begin
    Clear = 1'b0; CON_FF = 1'b0; Stop = 1'b0; IR = 32'h6908001A;
    step(); step();
    chk("reset", 28'd0, 5'b0, 1'b0);
    Clear = 1'b1;

    fetch("ori", 32'h6908001A);
    step(); chk("ori_T3", GRB | ROUT | YIN, 5'b0, 1'b1);
    step(); chk("ori_T4", COUT | ZIN, 5'b01101, 1'b1);
    step(); chk("ori_T5", ZLOWOUT | GRA | RIN, 5'b0, 1'b1);

    fetch("ld", 32'h00800055);
    step(); chk("ld_T3", GRB | BAOUT | YIN, 5'b0, 1'b1);
    step(); chk("ld_T4", COUT | ZIN, 5'b00011, 1'b1);
    step(); chk("ld_T5", ZLOWOUT | MARIN, 5'b0, 1'b1);
    step(); chk("ld_T6", READ | MDRIN, 5'b0, 1'b1);
    step(); chk("ld_T7", MDROUT | GRA | RIN, 5'b0, 1'b1);

    fetch("br0", 32'h90000000);
    step(); chk("br0_T3", GRA | ROUT | CONIN, 5'b0, 1'b1);
    step(); chk("br0_T4", PCOUT | YIN, 5'b0, 1'b1);
    step(); chk("br0_T5", COUT | ZIN, 5'b00011, 1'b1);
    step(); chk("br0_T6", 28'd0, 5'b0, 1'b1);

    fetch("br1", 32'h90000000);
    CON_FF = 1'b1;
    step(); chk("br1_T3", GRA | ROUT | CONIN, 5'b0, 1'b1);
    step(); chk("br1_T4", PCOUT | YIN, 5'b0, 1'b1);
    step(); chk("br1_T5", COUT | ZIN, 5'b00011, 1'b1);
    step(); chk("br1_T6", ZLOWOUT | PCIN, 5'b0, 1'b1);
    CON_FF = 1'b0;

    fetch("mul", 32'h70000000);
`ifdef CONTROL_SEQ_MULDIV_EN
    step(); chk("mul_T3", GRA | ROUT | YIN, 5'b0, 1'b1);
    step(); chk("mul_T4", GRB | ROUT | ZIN, 5'b01110, 1'b1);
    step(); chk("mul_T5", ZLOWOUT | LOIN, 5'b0, 1'b1);
    step(); chk("mul_T6", ZHIOUT | HIIN, 5'b0, 1'b1);
`endif

    fetch("undef", 32'hA0000000);

    fetch("neg", 32'h80000000);
    step(); chk("neg_T3", GRB | ROUT | ZIN, 5'b10000, 1'b1);
    step(); chk("neg_T4", ZLOWOUT | GRA | RIN, 5'b0, 1'b1);

    fetch("out", 32'hB0000000);
    Stop = 1'b1;
    step(); chk("out_T3", GRA | ROUT | OUTPORTIN | STROBE, 5'b0, 1'b1);
    step(); chk("stop_halt", 28'd0, 5'b0, 1'b0);
    Stop = 1'b0;
    step(); chk("stop_halt_hold", 28'd0, 5'b0, 1'b0);
    Clear = 1'b0; #2; Clear = 1'b1;

    fetch("add", 32'h18000000);
    step(); chk("add_T3", GRB | ROUT | YIN, 5'b0, 1'b1);
    step(); chk("add_T4", GRC | ROUT | ZIN, 5'b00011, 1'b1);
    Clear = 1'b0; #1;
    chk("async_clear", 28'd0, 5'b0, 1'b0);
    step(); chk("clear_hold", 28'd0, 5'b0, 1'b0);
    Clear = 1'b1;

    fetch("halt", 32'hD0000000);
    step(); chk("halt_enter", 28'd0, 5'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(); chk("halt_stay", 28'd0, 5'b0, 1'b0);
    end
    Clear = 1'b0;
    step();
    Clear = 1'b1;
    fetch("restart", 32'h18000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
